// File: rtl/ysyx_22040237_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Package    : ysyx_22040237_defs
// Description: Shared widths, reset PC and IFU state encoding.
// Revision   : 1.0 - initial release
// ============================================================================
package ysyx_22040237_defs;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } ifu_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040237_ifu_pc.sv
`default_nettype none
// ============================================================================
// Module     : ysyx_22040237_ifu_pc
// Description: Architectural PC register with hold / +4 / redirect select.
// Revision   : 1.0 - initial release
// ============================================================================
module ysyx_22040237_ifu_pc
  import ysyx_22040237_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Redirect outranks sequential advance.
  always_comb begin
    w_pc_next = r_pc;
    if (redirect) begin
      w_pc_next = redirect_pc;
    end else if (advance) begin
      w_pc_next = r_pc + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/ysyx_22040237_ifu.sv
`default_nettype none
// ============================================================================
// Module     : ysyx_22040237_ifu
// Description: Single-outstanding instruction fetch unit with redirect drain.
// Revision   : 1.0 - initial release
// ============================================================================
module ysyx_22040237_ifu
  import ysyx_22040237_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [XLEN-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              inst_err_o
);

  ifu_state_e        r_state;
  ifu_state_e        w_state_next;
  logic [XLEN-1:0]   w_pc;
  logic              w_misaligned;
  logic              w_req_fire;
  logic              w_redirect;
  logic              w_advance;
  logic              w_load;
  logic [INST_W-1:0] w_load_inst;
  logic              w_load_err;
  logic [INST_W-1:0] r_inst;
  logic [XLEN-1:0]   r_pc_buf;
  logic              r_err;

  ysyx_22040237_ifu_pc #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (w_redirect),
    .redirect_pc(redirect_pc_i),
    .advance    (w_advance),
    .pc         (w_pc)
  );

  assign w_misaligned     = (w_pc[1:0] != 2'b00);
  assign imem_req_valid_o = (r_state == S_REQ) && !w_misaligned;
  assign imem_req_addr_o  = (r_state == S_REQ) ? w_pc : '0;
  assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;
  assign w_redirect       = redirect_i && (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_load       = 1'b0;
    w_load_inst  = '0;
    w_load_err   = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        // A request accepted alongside a redirect still owes a response.
        if (redirect_i) begin
          w_state_next = w_req_fire ? S_DRAIN : S_REQ;
        end else if (w_misaligned) begin
          w_state_next = S_OUT;
          w_load       = 1'b1;
          w_load_err   = 1'b1;
        end else if (w_req_fire) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          w_state_next = redirect_i ? S_REQ : S_OUT;
          w_load       = !redirect_i;
          w_load_inst  = imem_rsp_err_i ? '0 : imem_rsp_data_i;
          w_load_err   = imem_rsp_err_i;
        end else if (redirect_i) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid_i) begin
          w_state_next = S_REQ;
        end
      end
      S_OUT: begin
        if (redirect_i) begin
          w_state_next = S_REQ;
        end else if (inst_ready_i) begin
          w_state_next = S_REQ;
          w_advance    = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inst   <= '0;
      r_pc_buf <= '0;
      r_err    <= 1'b0;
    end else if (w_load) begin
      r_inst   <= w_load_inst;
      r_pc_buf <= w_pc;
      r_err    <= w_load_err;
    end
  end

  assign inst_valid_o = (r_state == S_OUT) && !redirect_i;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc_buf;
  assign inst_err_o   = r_err;

endmodule
`default_nettype wire
